// File: rtl/control_gen.sv
// RV32I opcode-class decoder: U/J-type select, illegal-opcode flag, and
// registered debug copies (select, sticky illegal flag, saturating counter).
module control_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_out_d,
    output logic [1:0]       U_control,
    output logic             u_type,
    output logic             illegal_op,
    output logic [1:0]       U_control_q,
    output logic             illegal_seen,
    output logic [CNT_W-1:0] illegal_cnt
);

    always_comb begin
        U_control = 2'b00;
        case (opcode_out_d)
            7'b1101111: U_control = 2'b11;  // JAL
            7'b0110111: U_control = 2'b01;  // LUI
            7'b0010111: U_control = 2'b10;  // AUIPC
            default:    U_control = 2'b00;
        endcase
    end

    assign u_type = |U_control;

    always_comb begin
        illegal_op = 1'b1;
        case (opcode_out_d)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
            7'b0001111, 7'b1110011: illegal_op = 1'b0;
            default:                illegal_op = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            U_control_q  <= 2'b00;
            illegal_seen <= 1'b0;
            illegal_cnt  <= '0;
        end else begin
            U_control_q <= U_control;
            if (illegal_op) begin
                illegal_seen <= 1'b1;
                // Counter saturates at all-ones rather than wrapping
                if (illegal_cnt != '1)
                    illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_gen.sv
// Directed bench for control_gen: combinational decode, registered select,
// illegal-opcode bookkeeping, and counter saturation with a narrow counter.
module tb_control_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [1:0] u_ctl;
    logic       u_typ;
    logic       ill;
    logic [1:0] u_ctl_q;
    logic       seen;
    logic [7:0] cnt;

    logic       rst2_n;
    logic [6:0] opcode2;
    logic [1:0] u_ctl2;
    logic       u_typ2;
    logic       ill2;
    logic [1:0] u_ctl_q2;
    logic       seen2;
    logic [1:0] cnt2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    control_gen #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_out_d (opcode),
        .U_control    (u_ctl),
        .u_type       (u_typ),
        .illegal_op   (ill),
        .U_control_q  (u_ctl_q),
        .illegal_seen (seen),
        .illegal_cnt  (cnt)
    );

    control_gen #(.CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst_n        (rst2_n),
        .opcode_out_d (opcode2),
        .U_control    (u_ctl2),
        .u_type       (u_typ2),
        .illegal_op   (ill2),
        .U_control_q  (u_ctl_q2),
        .illegal_seen (seen2),
        .illegal_cnt  (cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [6:0] op;
        logic [1:0] u;
        logic       illegal;
    } vec_t;

    vec_t vecs[7] = '{
        '{7'b1101111, 2'b11, 1'b0},
        '{7'b0110111, 2'b01, 1'b0},
        '{7'b0010111, 2'b10, 1'b0},
        '{7'b1010100, 2'b00, 1'b1},
        '{7'b0110011, 2'b00, 1'b0},
        '{7'b1100111, 2'b00, 1'b0},
        '{7'b1110011, 2'b00, 1'b0}
    };

    logic [1:0] sat_exp[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    initial begin
        int n_ill;
        int n_u;

        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        opcode  = 7'b0000000;
        opcode2 = 7'b0000000;
        #2;
        check("reset_u_q",  32'(u_ctl_q), 32'd0);
        check("reset_seen", 32'(seen),    32'd0);
        check("reset_cnt",  32'(cnt),     32'd0);

        // Combinational decode, held in reset so no register activity matters
        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            #1;
            check($sformatf("u_ctl_%b", vecs[i].op),   32'(u_ctl), 32'(vecs[i].u));
            check($sformatf("u_type_%b", vecs[i].op),  32'(u_typ), 32'(|vecs[i].u));
            check($sformatf("illegal_%b", vecs[i].op), 32'(ill),   32'(vecs[i].illegal));
        end

        n_ill = 0;
        n_u   = 0;
        for (int i = 0; i < 128; i++) begin
            opcode = 7'(i);
            #1;
            if (ill === 1'b1) n_ill++;
            if (u_ctl !== 2'b00) n_u++;
        end
        check("sweep_illegal_count", 32'(n_ill), 32'd117);
        check("sweep_u_count",       32'(n_u),   32'd3);

        // Registered select: 1-cycle latency, async clear mid-cycle
        @(negedge clk);
        opcode = 7'b0110111;
        rst_n  = 1'b1;
        #1;
        check("u_q_before_edge", 32'(u_ctl_q), 32'd0);
        @(posedge clk); #1;
        check("u_q_after_edge", 32'(u_ctl_q), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("u_q_async_clear", 32'(u_ctl_q), 32'd0);

        // Illegal bookkeeping: 3 illegal edges, then 2 legal edges
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 7'b1010100;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("ill_cnt_step%0d", k), 32'(cnt), 32'(k));
        end
        check("seen_set", 32'(seen), 32'd1);
        @(negedge clk);
        opcode = 7'b0010011;
        repeat (2) @(posedge clk);
        #1;
        check("cnt_hold",  32'(cnt),     32'd3);
        check("seen_hold", 32'(seen),    32'd1);
        check("u_q_addi",  32'(u_ctl_q), 32'd0);
        rst_n = 1'b0;
        #1;
        check("cnt_reset",  32'(cnt),  32'd0);
        check("seen_reset", 32'(seen), 32'd0);

        // Saturation with a 2-bit counter
        @(negedge clk);
        opcode2 = 7'b1111111;
        rst2_n  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("sat_cnt_edge%0d", k + 1), 32'(cnt2), 32'(sat_exp[k]));
        end
        check("sat_seen", 32'(seen2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
